rtc_bus_sequencer: RTL and testbench

- Executes the multiplexed address/data bus transactions to the external RTC chip for whichever mode the general control FSM has selected: I=init, L=read, E=write, M_S=status.
- Started by the control FSM's one-cycle sync pulse.
- Walks a register list, driving cs_n/ad/rd_n/wr_n with programmable phase timing.
- Hands read bytes to the time/date register file and fetches write bytes from it.

---
 rtl/rtc_bus_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed address/data bus transaction sequencer
module rtc_bus_sequencer #(
    parameter int unsigned T_PHASE   = 4,
    parameter int unsigned N_RD      = 9,
    parameter int unsigned N_WR      = 9,
    parameter logic [7:0]  RD_BASE   = 8'h21,
    parameter logic [7:0]  WR_BASE   = 8'h21,
    parameter logic [7:0]  INIT_ADDR = 8'h02,
    parameter logic [7:0]  INIT_V1   = 8'h10,
    parameter logic [7:0]  INIT_V2   = 8'h00,
    parameter logic [7:0]  STAT_ADDR = 8'hF0
) (
    input  logic       clk,
    input  logic       count_rst,
    input  logic [1:0] control,
    input  logic       sync,
    input  logic [7:0] wr_value,
    input  logic [7:0] bus_in,
    output logic [3:0] wr_idx,
    output logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad,
    output logic       rd_n,
    output logic       wr_n,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] MODE_I = 2'b00;
    localparam logic [1:0] MODE_L = 2'b01;
    localparam logic [1:0] MODE_E = 2'b10;
    localparam logic [7:0] T_LOAD  = 8'(T_PHASE - 1);
    localparam logic [7:0] RD_LAST = 8'(N_RD - 1);
    localparam logic [7:0] WR_LAST = 8'(N_WR - 1);

    typedef enum logic [3:0] {
        IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, GAP, DONE
    } state_t;

    state_t     state, nxt_state;
    logic [7:0] timer, nxt_timer;
    logic [7:0] idx, nxt_idx;
    logic [1:0] mode, nxt_mode;
    logic       pend, nxt_pend;
    logic       arm, nxt_arm;
    logic [3:0] nxt_wr_idx, nxt_rd_idx;
    logic [7:0] nxt_rd_data, nxt_bus_out;
    logic       nxt_rd_valid, nxt_bus_oe, nxt_cs_n, nxt_ad, nxt_rd_n, nxt_wr_n;
    logic       nxt_busy, nxt_done;
    logic       tick, is_wr, start_acc;
    logic [1:0] acc_mode;
    logic [7:0] acc_idx, wr_byte;

    function automatic logic [7:0] addr_of(input logic [1:0] m, input logic [7:0] i);
        case (m)
            MODE_L:  addr_of = RD_BASE + i;
            MODE_E:  addr_of = WR_BASE + i;
            MODE_I:  addr_of = INIT_ADDR;
            default: addr_of = STAT_ADDR;
        endcase
    endfunction

    function automatic logic [7:0] last_of(input logic [1:0] m);
        case (m)
            MODE_L:  last_of = RD_LAST;
            MODE_E:  last_of = WR_LAST;
            MODE_I:  last_of = 8'd1;
            default: last_of = 8'd0;
        endcase
    endfunction

    assign tick    = (timer == 8'd0);
    assign is_wr   = (mode == MODE_E) || (mode == MODE_I);
    assign wr_byte = (mode == MODE_E) ? wr_value : ((idx == 8'd0) ? INIT_V1 : INIT_V2);

    // Next-state and next-output computation; every output is registered from these values
    always_comb begin
        nxt_state    = state;
        nxt_timer    = timer;
        nxt_idx      = idx;
        nxt_mode     = mode;
        nxt_pend     = pend;
        nxt_arm      = arm;
        nxt_wr_idx   = wr_idx;
        nxt_rd_idx   = rd_idx;
        nxt_rd_data  = rd_data;
        nxt_rd_valid = 1'b0;
        nxt_bus_out  = bus_out;
        nxt_bus_oe   = bus_oe;
        nxt_cs_n     = cs_n;
        nxt_ad       = ad;
        nxt_rd_n     = rd_n;
        nxt_wr_n     = wr_n;
        nxt_busy     = busy;
        nxt_done     = 1'b0;
        start_acc    = 1'b0;
        acc_mode     = mode;
        acc_idx      = idx;

        if (sync && busy && (state != DONE)) begin
            nxt_pend = 1'b1;
        end

        case (state)
            IDLE: begin
                if (arm) begin
                    nxt_arm   = 1'b0;
                    start_acc = 1'b1;
                end else if (sync) begin
                    nxt_mode = control;
                    nxt_idx  = 8'd0;
                    nxt_busy = 1'b1;
                    nxt_arm  = 1'b1;
                end
            end
            A_SET: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state = A_STB;
                    nxt_wr_n  = 1'b0;
                end
            end
            A_STB: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state = A_HOLD;
                    nxt_wr_n  = 1'b1;
                end
            end
            A_HOLD: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state  = D_SET;
                    nxt_ad     = 1'b1;
                    nxt_bus_oe = is_wr;
                    if (is_wr) begin
                        nxt_bus_out = wr_byte;
                    end
                end
            end
            D_SET: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state = D_STB;
                    if (is_wr) begin
                        nxt_wr_n = 1'b0;
                    end else begin
                        nxt_rd_n = 1'b0;
                    end
                end
            end
            D_STB: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state = D_HOLD;
                    nxt_wr_n  = 1'b1;
                    nxt_rd_n  = 1'b1;
                    if (!is_wr) begin
                        nxt_rd_data  = bus_in;
                        nxt_rd_valid = 1'b1;
                        nxt_rd_idx   = (mode == MODE_L) ? idx[3:0] : 4'd15;
                    end
                end
            end
            D_HOLD: begin
                nxt_timer = tick ? T_LOAD : timer - 8'd1;
                if (tick) begin
                    nxt_state  = GAP;
                    nxt_cs_n   = 1'b1;
                    nxt_bus_oe = 1'b0;
                end
            end
            GAP: begin
                if (idx == last_of(mode)) begin
                    nxt_state = DONE;
                    nxt_done  = 1'b1;
                end else begin
                    start_acc = 1'b1;
                    acc_idx   = idx + 8'd1;
                end
            end
            DONE: begin
                nxt_pend = 1'b0;
                if (pend || sync) begin
                    start_acc = 1'b1;
                    acc_mode  = control;
                    acc_idx   = 8'd0;
                end else begin
                    nxt_state = IDLE;
                    nxt_busy  = 1'b0;
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (start_acc) begin
            nxt_state   = A_SET;
            nxt_timer   = T_LOAD;
            nxt_mode    = acc_mode;
            nxt_idx     = acc_idx;
            nxt_cs_n    = 1'b0;
            nxt_ad      = 1'b0;
            nxt_bus_oe  = 1'b1;
            nxt_bus_out = addr_of(acc_mode, acc_idx);
            if (acc_mode == MODE_E) begin
                nxt_wr_idx = acc_idx[3:0];
            end
        end
    end

    // State, timer, index and registered outputs; reset releases the bus at once
    always_ff @(posedge clk or posedge count_rst) begin
        if (count_rst) begin
            state    <= IDLE;
            timer    <= 8'd0;
            idx      <= 8'd0;
            mode     <= MODE_I;
            pend     <= 1'b0;
            arm      <= 1'b0;
            wr_idx   <= 4'd0;
            rd_idx   <= 4'd0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
            bus_out  <= 8'd0;
            bus_oe   <= 1'b0;
            cs_n     <= 1'b1;
            ad       <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt_state;
            timer    <= nxt_timer;
            idx      <= nxt_idx;
            mode     <= nxt_mode;
            pend     <= nxt_pend;
            arm      <= nxt_arm;
            wr_idx   <= nxt_wr_idx;
            rd_idx   <= nxt_rd_idx;
            rd_data  <= nxt_rd_data;
            rd_valid <= nxt_rd_valid;
            bus_out  <= nxt_bus_out;
            bus_oe   <= nxt_bus_oe;
            cs_n     <= nxt_cs_n;
            ad       <= nxt_ad;
            rd_n     <= nxt_rd_n;
            wr_n     <= nxt_wr_n;
            busy     <= nxt_busy;
            done     <= nxt_done;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

    localparam int T    = 2;
    localparam int N_RD = 3;
    localparam int N_WR = 4;

    logic       clk = 1'b0;
    logic       count_rst;
    logic [1:0] control;
    logic       sync;
    logic [7:0] wr_value;
    logic [7:0] bus_in;
    logic [3:0] wr_idx, rd_idx;
    logic [7:0] rd_data, bus_out;
    logic       rd_valid, bus_oe, cs_n, ad, rd_n, wr_n, busy, done;

    always #5 clk = ~clk;

    assign wr_value = {4'h0, wr_idx} + 8'h30;

    rtc_bus_sequencer #(
        .T_PHASE(T), .N_RD(N_RD), .N_WR(N_WR),
        .RD_BASE(8'h21), .WR_BASE(8'h21), .INIT_ADDR(8'h02),
        .INIT_V1(8'h10), .INIT_V2(8'h00), .STAT_ADDR(8'hF0)
    ) dut (
        .clk(clk), .count_rst(count_rst), .control(control), .sync(sync),
        .wr_value(wr_value), .bus_in(bus_in), .wr_idx(wr_idx), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_valid(rd_valid), .bus_out(bus_out), .bus_oe(bus_oe),
        .cs_n(cs_n), .ad(ad), .rd_n(rd_n), .wr_n(wr_n), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       cs_n, ad, rd_n, wr_n, bus_oe;
        logic [7:0] bus_out;
        logic       rd_valid;
        logic [7:0] rd_data;
        logic [3:0] rd_idx;
        logic       done, busy;
        logic [3:0] wr_idx;
    } obs_t;

    typedef struct packed {
        obs_t       o;
        logic [7:0] bin;
    } exp_t;

    exp_t        q[$];
    logic        last_done, pend;
    logic [3:0]  cur_wr;
    int          total, bad;
    logic [7:0]  addr_log[$], data_log[$];
    logic [11:0] rd_log[$];
    int          done_cnt, gap_cnt;
    logic        rd_low, prev_wr_n;

    function automatic obs_t idle_obs(input logic b);
        obs_t r;
        r        = '0;
        r.cs_n   = 1'b1;
        r.ad     = 1'b1;
        r.rd_n   = 1'b1;
        r.wr_n   = 1'b1;
        r.busy   = b;
        r.wr_idx = cur_wr;
        return r;
    endfunction

    function automatic obs_t sample_obs();
        obs_t r;
        r.cs_n     = cs_n;
        r.ad       = ad;
        r.rd_n     = rd_n;
        r.wr_n     = wr_n;
        r.bus_oe   = bus_oe;
        r.bus_out  = bus_oe ? bus_out : 8'h00;
        r.rd_valid = rd_valid;
        r.rd_data  = rd_valid ? rd_data : 8'h00;
        r.rd_idx   = rd_valid ? rd_idx : 4'h0;
        r.done     = done;
        r.busy     = busy;
        r.wr_idx   = wr_idx;
        return r;
    endfunction

    // Expected bus trace of one whole sequence: n accesses of six T-cycle phases plus a gap, then DONE
    task automatic gen_seq(input logic [1:0] m);
        int         n, ph;
        exp_t       e;
        logic [7:0] addr, data, rdv;
        logic       isw;
        n   = (m == 2'b01) ? N_RD : (m == 2'b10) ? N_WR : (m == 2'b00) ? 2 : 1;
        isw = (m == 2'b10) || (m == 2'b00);
        for (int a = 0; a < n; a++) begin
            case (m)
                2'b01:   addr = 8'h21 + 8'(a);
                2'b10:   addr = 8'h21 + 8'(a);
                2'b00:   addr = 8'h02;
                default: addr = 8'hF0;
            endcase
            data = (m == 2'b10) ? 8'h30 + 8'(a) : ((a == 0) ? 8'h10 : 8'h00);
            rdv  = (m == 2'b11) ? 8'h80 : ((a == 1) ? 8'h5A : 8'h40 + 8'(a));
            if (m == 2'b10) cur_wr = 4'(a);
            for (int c = 0; c <= 6 * T; c++) begin
                e.o   = idle_obs(1'b1);
                e.bin = (c >= 3 * T && c < 6 * T) ? rdv : 8'hEE;
                ph    = c / T;
                if (c < 6 * T) begin
                    e.o.cs_n = 1'b0;
                    if (ph < 3) begin
                        e.o.ad      = 1'b0;
                        e.o.bus_oe  = 1'b1;
                        e.o.bus_out = addr;
                        e.o.wr_n    = (ph == 1) ? 1'b0 : 1'b1;
                    end else begin
                        e.o.bus_oe  = isw;
                        e.o.bus_out = isw ? data : 8'h00;
                        if (ph == 4) begin
                            if (isw) e.o.wr_n = 1'b0;
                            else     e.o.rd_n = 1'b0;
                        end
                        if (!isw && c == 5 * T) begin
                            e.o.rd_valid = 1'b1;
                            e.o.rd_data  = rdv;
                            e.o.rd_idx   = (m == 2'b11) ? 4'd15 : 4'(a);
                        end
                    end
                end
                q.push_back(e);
            end
        end
        e.o      = idle_obs(1'b1);
        e.o.done = 1'b1;
        e.bin    = 8'hEE;
        q.push_back(e);
    endtask

    // Model reacts to sync and pending restarts at the same edges the DUT samples
    initial begin
        logic busy_m;
        forever begin
            @(posedge clk);
            if (!count_rst) begin
                busy_m = (q.size() != 0) || last_done;
                if (sync && busy_m) pend = 1'b1;
                if (last_done) begin
                    last_done = 1'b0;
                    if (pend) begin
                        pend = 1'b0;
                        gen_seq(control);
                    end
                end else if (sync && !busy_m) begin
                    exp_t e;
                    e.o   = idle_obs(1'b1);
                    e.bin = 8'hEE;
                    q.push_back(e);
                    gen_seq(control);
                end
            end
        end
    end

    // Per-cycle comparison against the model, bus_in driving and event logging
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (!count_rst) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                end else begin
                    e.o   = idle_obs(1'b0);
                    e.bin = 8'hEE;
                end
                a = sample_obs();
                total++;
                if (a !== e.o) begin
                    bad++;
                    $display("FAIL cycle_check t=%0t actual=%h required=%h", $time, a, e.o);
                end
                if (e.o.done) last_done = 1'b1;
                bus_in = e.bin;
                if (!ad && !wr_n && prev_wr_n) addr_log.push_back(bus_out);
                if (ad && !wr_n && prev_wr_n) data_log.push_back(bus_out);
                if (rd_valid) rd_log.push_back({rd_idx, rd_data});
                if (!rd_n) rd_low = 1'b1;
                if (done) done_cnt++;
                if (done_cnt == 1 && !busy) gap_cnt++;
                prev_wr_n = wr_n;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
        rd_log.delete();
        done_cnt = 0;
        gap_cnt  = 0;
        rd_low   = 1'b0;
    endtask

    task automatic pulse_sync(input logic [1:0] m);
        @(negedge clk);
        #2;
        control = m;
        sync    = 1'b1;
        @(negedge clk);
        #2;
        sync = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #3;
            k++;
        end while ((q.size() != 0 || last_done || pend) && k < budget);
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_idle timeout after %0d cycles", k);
        end
    endtask

    initial begin
        int n, k;
        count_rst = 1'b1;
        sync      = 1'b0;
        control   = 2'b00;
        bus_in    = 8'h00;
        total     = 0;
        bad       = 0;
        last_done = 1'b0;
        pend      = 1'b0;
        cur_wr    = 4'd0;
        prev_wr_n = 1'b1;
        clear_logs();
        repeat (3) @(negedge clk);
        check("reset_state",
              {cs_n, rd_n, wr_n, ad, bus_oe, busy, done, rd_valid, wr_idx, rd_idx, bus_out, rd_data},
              {4'b1111, 4'b0000, 4'h0, 4'h0, 8'h00, 8'h00});
        #2 count_rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: three reads, length of the sequence, busy drop
        clear_logs();
        pulse_sync(2'b01);
        k = 0;
        while (cs_n && k < 20) begin @(negedge clk); #3; k++; end
        n = 1;
        while (!done && n < 100) begin @(negedge clk); #3; n++; end
        check("t1_len", n, 40);
        @(negedge clk);
        #3;
        check("t1_busy_after", busy, 0);
        wait_idle(50);
        check("t1_rd_count", rd_log.size(), 3);
        check("t1_rd1", rd_log[1], {4'd1, 8'h5A});
        check("t1_addr", {addr_log[0], addr_log[1], addr_log[2]}, 24'h212223);

        // 2: writes with data from the register file lookup
        clear_logs();
        pulse_sync(2'b10);
        wait_idle(200);
        check("t2_addr", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, 32'h21222324);
        check("t2_data", {data_log[0], data_log[1], data_log[2], data_log[3]}, 32'h30313233);
        check("t2_rd_n_high", rd_low, 0);

        // 3: init sequence
        clear_logs();
        pulse_sync(2'b00);
        wait_idle(200);
        check("t3_writes", {8'(addr_log.size()), addr_log[0], addr_log[1], data_log[0], data_log[1]},
              40'h02_02_02_10_00);
        check("t3_wr_idx", wr_idx, 4'd3);
        check("t3_done", done_cnt, 1);

        // 4: status read
        clear_logs();
        pulse_sync(2'b11);
        bus_in = 8'h80;
        wait_idle(200);
        check("t4_rd", {20'(rd_log.size()), rd_log[0]}, {20'd1, 4'hF, 8'h80});
        check("t4_addr", addr_log[0], 8'hF0);

        // 5: merged pending syncs, control change takes effect only on restart
        clear_logs();
        pulse_sync(2'b01);
        repeat (5) @(negedge clk);
        pulse_sync(2'b10);
        repeat (3) @(negedge clk);
        pulse_sync(2'b10);
        repeat (4) @(negedge clk);
        pulse_sync(2'b10);
        wait_idle(400);
        check("t5_done_cnt", done_cnt, 2);
        check("t5_no_idle_gap", gap_cnt, 0);
        check("t5_reads", rd_log.size(), 3);
        check("t5_writes", data_log.size(), 4);

        // 6: asynchronous reset during a read strobe
        clear_logs();
        pulse_sync(2'b01);
        k = 0;
        while (rd_n && k < 50) begin @(negedge clk); #3; k++; end
        check("t6_reached_dstb", rd_n, 0);
        count_rst = 1'b1;
        q.delete();
        pend      = 1'b0;
        last_done = 1'b0;
        cur_wr    = 4'd0;
        #1;
        check("t6_async_release", {cs_n, rd_n, wr_n, bus_oe}, 4'b1110);
        repeat (3) @(negedge clk);
        #2 count_rst = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        check("t6_no_rd_valid", rd_log.size(), 0);
        check("t6_no_done", done_cnt, 0);
        clear_logs();
        pulse_sync(2'b01);
        wait_idle(200);
        check("t6_restart_addr", addr_log[0], 8'h21);
        check("t6_restart_rd0", {20'(rd_log.size()), rd_log[0]}, {20'd3, 4'd0, 8'h40});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
